// File: rtl/alu_serial_ctrl.sv
// Bit-serial 2-op arithmetic / 2-op logic unit with valid/ready command and response handshakes.
// One operand bit per clock, LSB first, through a single 1-bit slice with a registered carry.

module alu_bit_slice (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic [1:0] op_i,
  output logic       r_o,
  output logic       c_o
);
  logic bx;

  always_comb begin
    bx  = b_i ^ op_i[0];  // subtract inverts b; cin comes from the requester
    r_o = 1'b0;
    c_o = 1'b0;
    case (op_i)
      2'b00, 2'b01: begin
        r_o = a_i ^ bx ^ c_i;
        c_o = (a_i & bx) | (a_i & c_i) | (bx & c_i);
      end
      2'b10:   r_o = a_i & b_i;
      default: r_o = a_i | b_i;
    endcase
  end
endmodule

module alu_serial_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_opcode,
  input  logic             cmd_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             busy
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic [1:0]       op_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic             rsp_valid_q, rsp_cout_q, rsp_zero_q, busy_q, cmd_ready_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             slice_r, slice_c;

  alu_bit_slice u_slice (
    .a_i  (a_q[idx_q]),
    .b_i  (b_q[idx_q]),
    .c_i  (carry_q),
    .op_i (op_q),
    .r_o  (slice_r),
    .c_o  (slice_c)
  );

  // Result bits shift in from the top so the word is aligned after WIDTH steps.
  assign acc_d = {slice_r, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      acc_q        <= '0;
      carry_q      <= 1'b0;
      idx_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            a_q         <= cmd_a;
            b_q         <= cmd_b;
            op_q        <= cmd_opcode;
            carry_q     <= cmd_cin & ~cmd_opcode[1];  // logic ops keep carry at 0
            idx_q       <= '0;
            acc_q       <= '0;
            state_q     <= RUN;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
          end
        end
        RUN: begin
          carry_q <= slice_c;
          acc_q   <= acc_d;
          idx_q   <= idx_q + IW'(1);
          if (idx_q == LAST) begin
            state_q      <= DONE;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= acc_d;
            rsp_cout_q   <= slice_c;
            rsp_zero_q   <= (acc_d == '0);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed + random bench for alu_serial_ctrl against an arithmetic reference model.
module tb_alu_serial_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, cmd_valid, cmd_ready, cmd_cin, rsp_valid, rsp_ready;
  logic [W-1:0] cmd_a, cmd_b, rsp_result;
  logic [1:0]   cmd_opcode;
  logic         rsp_cout, rsp_zero, busy;

  int checks = 0;
  int errors = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode), .cmd_cin(cmd_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on whole words.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input logic cin, output logic [W-1:0] r, output logic co);
    logic [31:0]  s;
    logic [W-1:0] nb;
    nb = ~b;
    case (op)
      2'd0:    s = 32'(a) + 32'(b) + 32'(cin);
      2'd1:    s = 32'(a) + 32'(nb) + 32'(cin);
      2'd2:    s = 32'(a & b);
      default: s = 32'(a | b);
    endcase
    r  = s[W-1:0];
    co = op[1] ? 1'b0 : s[W];
  endtask

  task automatic scramble();
    cmd_a      = W'($urandom);
    cmd_b      = W'($urandom);
    cmd_opcode = 2'($urandom);
    cmd_cin    = 1'($urandom);
  endtask

  // Issue one command, wait for the response, hold it for `hold` cycles, then consume it.
  task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         input logic cin, input int hold,
                         output logic [W-1:0] obs_r, output logic obs_c, output logic obs_z);
    logic [W-1:0] er;
    logic         ec;
    int           lat;
    model(a, b, op, cin, er, ec);
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_cin = cin;
    @(posedge clk);
    @(negedge clk);
    chk("busy_run", 32'(busy), 32'd1);
    chk("cmd_ready_run", 32'(cmd_ready), 32'd0);
    lat = 0;
    for (int k = 1; k <= W + 3; k++) begin
      cmd_valid = 1'($urandom);
      rsp_ready = 1'($urandom);
      scramble();
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    rsp_ready = 1'b0;
    chk("latency", 32'(lat), 32'(W));
    chk("result", 32'(rsp_result), 32'(er));
    chk("cout", 32'(rsp_cout), 32'(ec));
    chk("zero", 32'(rsp_zero), 32'(er == '0));
    obs_r = rsp_result; obs_c = rsp_cout; obs_z = rsp_zero;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      scramble();
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_result", 32'(rsp_result), 32'(er));
      chk("hold_cout", 32'(rsp_cout), 32'(ec));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;  // must not be taken on the consuming edge
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("consume_valid", 32'(rsp_valid), 32'd0);
    chk("consume_busy", 32'(busy), 32'd0);
    chk("consume_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("retain_result", 32'(rsp_result), 32'(er));
    chk("retain_cout", 32'(rsp_cout), 32'(ec));
  endtask

  logic [W-1:0] r;
  logic         c, z;

  initial begin
    rst = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b1;
    cmd_a = '1; cmd_b = '1; cmd_opcode = 2'd0; cmd_cin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_cout", 32'(rsp_cout), 32'd0);
    chk("rst_zero", 32'(rsp_zero), 32'd0);
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;

    run_cmd(4'b0111, 4'b0011, 2'b00, 1'b0, 0, r, c, z);
    chk("add_r", 32'(r), 32'b1010); chk("add_c", 32'(c), 32'd0); chk("add_z", 32'(z), 32'd0);
    run_cmd(4'b0101, 4'b0011, 2'b01, 1'b1, 1, r, c, z);
    chk("sub1_r", 32'(r), 32'b0010); chk("sub1_c", 32'(c), 32'd1);
    run_cmd(4'b0011, 4'b0101, 2'b01, 1'b1, 0, r, c, z);
    chk("sub2_r", 32'(r), 32'b1110); chk("sub2_c", 32'(c), 32'd0);
    run_cmd(4'b1100, 4'b1010, 2'b10, 1'b1, 0, r, c, z);
    chk("and_r", 32'(r), 32'b1000); chk("and_c", 32'(c), 32'd0);
    run_cmd(4'b1100, 4'b1010, 2'b11, 1'b1, 0, r, c, z);
    chk("or_r", 32'(r), 32'b1110); chk("or_c", 32'(c), 32'd0);
    run_cmd(4'b1111, 4'b0001, 2'b00, 1'b0, 0, r, c, z);
    chk("wrap_r", 32'(r), 32'b0000); chk("wrap_c", 32'(c), 32'd1); chk("wrap_z", 32'(z), 32'd1);
    run_cmd(4'b0110, 4'b1001, 2'b00, 1'b1, 5, r, c, z);
    chk("bp_r", 32'(r), 32'b0000); chk("bp_c", 32'(c), 32'd1);

    // Reset two cycles after an accept, with the previous result still on the outputs.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 4'b0101; cmd_b = 4'b0110; cmd_opcode = 2'b00; cmd_cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; rsp_ready = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b0; cmd_valid = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_result", 32'(rsp_result), 32'd0);
    chk("mid_rst_cout", 32'(rsp_cout), 32'd0);
    chk("mid_rst_zero", 32'(rsp_zero), 32'd0);
    run_cmd(4'b0101, 4'b0110, 2'b00, 1'b0, 0, r, c, z);
    chk("post_rst_r", 32'(r), 32'b1011);

    for (int i = 0; i < 40; i++)
      run_cmd(W'($urandom), W'($urandom), 2'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), r, c, z);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
